// File: rtl/board_reveal_engine.sv
// board_reveal_engine: reveals a 5x5 minesweeper cell, counts adjacent mines,
// and tracks game-over / win.
// Build option: define REVEAL_FLOOD_EN to flood-fill zero-count regions
// (explicit stack + queued bitmap). Without it only the selected cell is revealed.
module board_reveal_engine #(
    parameter int NUM_MINES   = 5,
    parameter int STACK_DEPTH = 25
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [31:0] req_id,
    output logic        ack,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic        busy,
    output logic        game_over,
    output logic        win
);

    localparam logic [4:0] SAFE_CELLS  = 5'(25 - NUM_MINES);
    localparam logic [3:0] ST_REV_MINE = 4'd9;
    localparam logic [3:0] ST_HID_SAFE = 4'd10;
    localparam logic [3:0] ST_HID_MINE = 4'd11;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_TGT, S_CHK_TGT, S_NB_ADDR, S_NB_DATA, S_WRITE,
`ifdef REVEAL_FLOOD_EN
        S_PUSH, S_POP,
`endif
        S_ACK, S_END
    } state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cur;
    logic [2:0]  r_k;          // neighbour index; wraps 7->0 so PUSH starts at NW
    logic [3:0]  r_cnt;
    logic [4:0]  r_revealed;
    logic        r_game_over, r_win;

    logic [3:0]        w_status;
    logic [4:0]        w_row, w_col, w_nid5;
    logic signed [2:0] w_dr, w_dc;
    logic signed [6:0] w_dr7, w_dc7, w_nr, w_nc, w_nid;
    logic              w_nb_ok;
    logic              w_accept, w_set_go, w_nb_start, w_k_inc, w_cnt_inc, w_reveal;
    logic              w_unused;

`ifdef REVEAL_FLOOD_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    logic [24:0]     r_queued;
    logic [4:0]      r_stack [STACK_DEPTH];
    logic [SP_W-1:0] r_sp;
    logic            w_push, w_pop, w_sp_empty;
    assign w_sp_empty = (r_sp == '0);
`endif

    assign w_status  = mem_rdata[3:0];
    assign w_unused  = ^{mem_rdata[31:4], w_nid[6:5]};
    assign game_over = r_game_over;
    assign win       = r_win;

    // Neighbour geometry from the registered cell: offset by scan order, bounds on row/col.
    assign w_row  = r_cur / 5'd5;
    assign w_col  = r_cur % 5'd5;
    assign w_dr7  = $signed({{4{w_dr[2]}}, w_dr});
    assign w_dc7  = $signed({{4{w_dc[2]}}, w_dc});
    assign w_nr   = $signed({2'b00, w_row}) + w_dr7;
    assign w_nc   = $signed({2'b00, w_col}) + w_dc7;
    assign w_nid  = $signed({2'b00, r_cur}) + (w_dr7 * 7'sd5) + w_dc7;
    assign w_nid5 = w_nid[4:0];
    assign w_nb_ok = (w_nr >= 7'sd0) && (w_nr <= 7'sd4) && (w_nc >= 7'sd0) && (w_nc <= 7'sd4);

    // Decode scan order NW, N, NE, W, E, SW, S, SE into row/col offsets.
    always_comb begin
        w_dr = 3'sd0;
        w_dc = 3'sd0;
        case (r_k)
            3'd0: begin w_dr = -3'sd1; w_dc = -3'sd1; end
            3'd1: begin w_dr = -3'sd1; w_dc =  3'sd0; end
            3'd2: begin w_dr = -3'sd1; w_dc =  3'sd1; end
            3'd3: begin w_dr =  3'sd0; w_dc = -3'sd1; end
            3'd4: begin w_dr =  3'sd0; w_dc =  3'sd1; end
            3'd5: begin w_dr =  3'sd1; w_dc = -3'sd1; end
            3'd6: begin w_dr =  3'sd1; w_dc =  3'sd0; end
            default: begin w_dr = 3'sd1; w_dc = 3'sd1; end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic, memory port drive and datapath strobes.
    always_comb begin
        w_next     = r_state;
        ack        = 1'b0;
        busy       = (r_state != S_IDLE);
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wen    = 1'b0;
        w_accept   = 1'b0;
        w_set_go   = 1'b0;
        w_nb_start = 1'b0;
        w_k_inc    = 1'b0;
        w_cnt_inc  = 1'b0;
        w_reveal   = 1'b0;
`ifdef REVEAL_FLOOD_EN
        w_push     = 1'b0;
        w_pop      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if ((req_id >= 32'd25) || r_game_over || r_win) begin
                        w_next = S_ACK;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = S_RD_TGT;
                    end
                end
            end
            S_RD_TGT: begin
                mem_addr = {27'd0, r_cur};
                w_next   = S_CHK_TGT;
            end
            S_CHK_TGT: begin
                if (w_status == ST_HID_MINE) begin
                    mem_addr  = {27'd0, r_cur};
                    mem_wdata = {28'd0, ST_REV_MINE};
                    mem_wen   = 1'b1;
                    w_set_go  = 1'b1;
                    w_next    = S_ACK;
                end else if (w_status == ST_HID_SAFE) begin
                    w_nb_start = 1'b1;
                    w_next     = S_NB_ADDR;
                end else begin
`ifdef REVEAL_FLOOD_EN
                    w_next = w_sp_empty ? S_ACK : S_POP;
`else
                    w_next = S_ACK;
`endif
                end
            end
            S_NB_ADDR: begin
                if (w_nb_ok) begin
                    mem_addr = {27'd0, w_nid5};
                    w_next   = S_NB_DATA;
                end else begin
                    w_k_inc = 1'b1;
                    w_next  = (r_k == 3'd7) ? S_WRITE : S_NB_ADDR;
                end
            end
            S_NB_DATA: begin
                w_k_inc   = 1'b1;
                w_cnt_inc = (w_status == ST_HID_MINE);
                w_next    = (r_k == 3'd7) ? S_WRITE : S_NB_ADDR;
            end
            S_WRITE: begin
                mem_addr  = {27'd0, r_cur};
                mem_wdata = {28'd0, r_cnt};
                mem_wen   = 1'b1;
                w_reveal  = 1'b1;
`ifdef REVEAL_FLOOD_EN
                if (r_cnt == 4'd0) w_next = S_PUSH;
                else               w_next = w_sp_empty ? S_ACK : S_POP;
`else
                w_next = S_ACK;
`endif
            end
`ifdef REVEAL_FLOOD_EN
            S_PUSH: begin
                w_k_inc = 1'b1;
                w_push  = w_nb_ok && !r_queued[w_nid5] && (r_sp != SP_W'(STACK_DEPTH));
                w_next  = (r_k == 3'd7) ? S_POP : S_PUSH;
            end
            S_POP: begin
                if (w_sp_empty) begin
                    w_next = S_ACK;
                end else begin
                    w_pop  = 1'b1;
                    w_next = S_RD_TGT;
                end
            end
`endif
            S_ACK: begin
                ack    = 1'b1;
                w_next = S_END;
            end
            S_END: begin
                if (!req) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Cell pointer, neighbour counter and sticky game status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur       <= '0;
            r_k         <= '0;
            r_cnt       <= '0;
            r_revealed  <= '0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
        end else begin
            if (w_accept) r_cur <= req_id[4:0];
`ifdef REVEAL_FLOOD_EN
            if (w_pop) r_cur <= r_stack[r_sp - SP_W'(1)];
`endif
            if (w_nb_start) begin
                r_k   <= '0;
                r_cnt <= '0;
            end else begin
                if (w_k_inc)   r_k   <= r_k + 3'd1;
                if (w_cnt_inc) r_cnt <= r_cnt + 4'd1;
            end
            if (w_set_go) r_game_over <= 1'b1;
            if (w_reveal) begin
                r_revealed <= r_revealed + 5'd1;
                if ((r_revealed + 5'd1) == SAFE_CELLS) r_win <= 1'b1;
            end
        end
    end

`ifdef REVEAL_FLOOD_EN
    // Flood bookkeeping: queued bitmap and stack pointer, cleared per request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_queued <= '0;
            r_sp     <= '0;
        end else if (w_accept) begin
            r_queued <= '0;
            r_sp     <= '0;
        end else begin
            if (w_nb_start) r_queued[r_cur] <= 1'b1;
            if (w_push) begin
                r_queued[w_nid5] <= 1'b1;
                r_sp             <= r_sp + SP_W'(1);
            end
            if (w_pop) r_sp <= r_sp - SP_W'(1);
        end
    end

    // Stack storage; only entries below the pointer are ever read.
    always_ff @(posedge clk) begin
        if (w_push) r_stack[r_sp] <= w_nid5;
    end
`endif

endmodule
